int_sched: RTL and testbench

- Nested, prioritised interrupt scheduler for the 5-stage pipeline.
- Latches edge-triggered requests and arbitrates them by priority against the level currently in service.
- Sequences the pipeline flush, EPC save and vector jump; on eret it restores from a hardware EPC stack.
- Drives the IF/ID, ID/EX and EX/MEM clear lines and the PC force/address pair.

---
 rtl/int_sched.sv | 211 +++++++++++++++++++++
 tb/tb_int_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/int_sched.sv
// ============================================================================
// Module   : int_sched
// Purpose  : Nested, prioritised interrupt scheduler for the 5-stage pipeline.
//            Captures rising edges on the request lines, arbitrates them
//            against the priority level currently in service, then sequences
//            pipeline flush, EPC save and vector jump. On eret it flushes and
//            returns to the EPC held on top of a small hardware stack.
// Ports    : clk        - clock, all state on rising edge
//            in_RST     - synchronous active-high reset
//            en         - pipeline advance enable (FSM moves only when 1)
//            irq        - raw request lines, rising-edge sensitive
//            mask       - per-source mask (1 = masked)
//            gie        - global interrupt enable
//            wb_pc      - resume address captured as EPC
//            eret       - eret instruction in WB this cycle
//            pending    - latched, unserviced requests
//            in_service - sources currently being serviced
//            depth      - EPC stack occupancy
//            flush_fd/flush_de/flush_ee - IF/ID, ID/EX, EX/MEM clears
//            force_pc   - PC override strobe ("force" is a reserved word)
//            faddr      - PC override address (holds when force_pc = 0)
//            busy       - FSM not idle
//            err        - sticky: eret seen with an empty stack
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_sched #(
  parameter int          NSRC       = 4,
  parameter int          DEPTH      = 3,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0200,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic            clk,
  input  logic            in_RST,
  input  logic            en,
  input  logic [NSRC-1:0] irq,
  input  logic [NSRC-1:0] mask,
  input  logic            gie,
  input  logic [31:0]     wb_pc,
  input  logic            eret,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] in_service,
  output logic [1:0]      depth,
  output logic            flush_fd,
  output logic            flush_de,
  output logic            flush_ee,
  output logic            force_pc,
  output logic [31:0]     faddr,
  output logic            busy,
  output logic            err
);

  localparam int         IDXW    = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam logic [1:0] c_DEPTH = 2'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_SAVE   = 3'd2,
    S_JUMP   = 3'd3,
    S_RFLUSH = 3'd4,
    S_RJUMP  = 3'd5
  } state_t;

  state_t            r_state;
  logic [NSRC-1:0]   r_irq_prev;
  logic [NSRC-1:0]   r_pending;
  logic [NSRC-1:0]   r_in_service;
  logic [1:0]        r_depth;
  logic [IDXW-1:0]   r_idx;
  logic [31:0]       r_epc;
  logic [31:0]       r_stk_pc  [DEPTH];
  logic [IDXW-1:0]   r_stk_idx [DEPTH];
  logic              r_flush;
  logic              r_force;
  logic [31:0]       r_faddr;
  logic              r_err;

  logic [NSRC-1:0]   w_rise;
  logic [NSRC-1:0]   w_elig;
  logic [NSRC-1:0]   w_take;
  logic [IDXW-1:0]   w_win;
  logic              w_any;
  logic              w_room;
  logic [1:0]        w_top;

  assign w_rise = irq & ~r_irq_prev;
  assign w_room = (r_depth < c_DEPTH);
  assign w_top  = r_depth - 2'd1;

  // A source may preempt only if no in-service source has an index >= its own,
  // i.e. the bits of in_service at or above i are all clear.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_elig[i] = r_pending[i] & ~mask[i] & gie & w_room & ~(|(r_in_service >> i));
    end
  end

  // Highest eligible index wins: later iterations overwrite earlier ones.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_elig[i]) begin
        w_win = IDXW'(i);
        w_any = 1'b1;
      end
    end
  end

  // Pending bit consumed only when the request is actually taken; eret wins.
  always_comb begin
    w_take = '0;
    if (r_state == S_IDLE && en && !eret && w_any) begin
      w_take[w_win] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (in_RST) begin
      r_state      <= S_IDLE;
      r_irq_prev   <= irq;   // a line held high through reset must not fire
      r_pending    <= '0;
      r_in_service <= '0;
      r_depth      <= '0;
      r_idx        <= '0;
      r_epc        <= '0;
      r_flush      <= 1'b0;
      r_force      <= 1'b0;
      r_faddr      <= '0;
      r_err        <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        r_stk_pc[k]  <= '0;
        r_stk_idx[k] <= '0;
      end
    end else begin
      r_irq_prev <= irq;
      // A new edge in the same cycle as the take leaves the bit set.
      r_pending  <= (r_pending & ~w_take) | w_rise;
      if (en) begin
        case (r_state)
          S_IDLE: begin
            if (eret) begin
              if (r_depth != 2'd0) begin
                r_state <= S_RFLUSH;
                r_flush <= 1'b1;
              end else begin
                r_err <= 1'b1;
              end
            end else if (w_any) begin
              r_idx   <= w_win;
              r_epc   <= wb_pc;
              r_state <= S_FLUSH;
              r_flush <= 1'b1;
            end
          end
          S_FLUSH: begin
            r_flush                 <= 1'b0;
            r_stk_pc[r_depth]       <= r_epc;
            r_stk_idx[r_depth]      <= r_idx;
            r_in_service[r_idx]     <= 1'b1;
            r_depth                 <= r_depth + 2'd1;
            r_state                 <= S_SAVE;
          end
          S_SAVE: begin
            r_force <= 1'b1;
            r_faddr <= VEC_BASE + (32'(r_idx) * VEC_STRIDE);
            r_state <= S_JUMP;
          end
          S_JUMP: begin
            r_force <= 1'b0;
            r_state <= S_IDLE;
          end
          S_RFLUSH: begin
            r_flush                          <= 1'b0;
            r_force                          <= 1'b1;
            r_faddr                          <= r_stk_pc[w_top];
            r_in_service[r_stk_idx[w_top]]   <= 1'b0;
            r_depth                          <= w_top;
            r_state                          <= S_RJUMP;
          end
          S_RJUMP: begin
            r_force <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_flush <= 1'b0;
            r_force <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign pending    = r_pending;
  assign in_service = r_in_service;
  assign depth      = r_depth;
  assign flush_fd   = r_flush;
  assign flush_de   = r_flush;
  assign flush_ee   = r_flush;
  assign force_pc   = r_force;
  assign faddr      = r_faddr;
  assign busy       = (r_state != S_IDLE);
  assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_int_sched.sv
// ============================================================================
// Module   : tb_int_sched
// Purpose  : Self-checking bench for int_sched: directed scenarios followed by
//            randomized traffic, all compared every cycle against a
//            queue-based reference model of the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_int_sched;

  localparam int          NSRC  = 4;
  localparam int          DEPTH = 3;
  localparam logic [31:0] VB    = 32'h0000_0200;
  localparam logic [31:0] VS    = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst, en, gie, eret;
  logic [3:0]  irq, mask;
  logic [31:0] wb_pc;
  logic [3:0]  pending, in_service;
  logic [1:0]  depth;
  logic        flush_fd, flush_de, flush_ee, force_pc, busy, err;
  logic [31:0] faddr;

  always #5 clk = ~clk;

  int_sched #(.NSRC(NSRC), .DEPTH(DEPTH), .VEC_BASE(VB), .VEC_STRIDE(VS)) u_dut (
    .clk(clk), .in_RST(rst), .en(en), .irq(irq), .mask(mask), .gie(gie),
    .wb_pc(wb_pc), .eret(eret), .pending(pending), .in_service(in_service),
    .depth(depth), .flush_fd(flush_fd), .flush_de(flush_de), .flush_ee(flush_ee),
    .force_pc(force_pc), .faddr(faddr), .busy(busy), .err(err)
  );

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] pc; int idx; } ent_t;
  ent_t        m_stk[$];
  int          m_cur;      // 0 idle, 1 flush, 2 save, 3 jump, 4 rflush, 5 rjump
  logic [3:0]  m_prev, m_pend;
  logic        m_err;
  logic [31:0] m_faddr, m_epc;
  int          m_idx;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int level();
    int l = -1;
    foreach (m_stk[k]) if (m_stk[k].idx > l) l = m_stk[k].idx;
    return l;
  endfunction

  function automatic logic [3:0] svc();
    logic [3:0] s = '0;
    foreach (m_stk[k]) s[m_stk[k].idx] = 1'b1;
    return s;
  endfunction

  task automatic model_step();
    logic [3:0] rise, take;
    int win;
    if (rst) begin
      m_stk.delete();
      m_cur = 0; m_pend = '0; m_err = 1'b0; m_faddr = '0; m_idx = 0; m_epc = '0;
      m_prev = irq;
      return;
    end
    rise = irq & ~m_prev;
    m_prev = irq;
    take = '0;
    if (en) begin
      case (m_cur)
        0: begin
          if (eret) begin
            if (m_stk.size() > 0) m_cur = 4; else m_err = 1'b1;
          end else begin
            win = -1;
            for (int i = 0; i < NSRC; i++)
              if (m_pend[i] && !mask[i] && gie && i > level() && m_stk.size() < DEPTH) win = i;
            if (win >= 0) begin
              m_idx = win; m_epc = wb_pc; take[win] = 1'b1; m_cur = 1;
            end
          end
        end
        1: begin m_stk.push_back('{m_epc, m_idx}); m_cur = 2; end
        2: begin m_faddr = VB + 32'(m_idx) * VS; m_cur = 3; end
        3: m_cur = 0;
        4: begin m_faddr = m_stk[$].pc; void'(m_stk.pop_back()); m_cur = 5; end
        default: m_cur = 0;
      endcase
    end
    m_pend = (m_pend & ~take) | rise;
  endtask

  task automatic check_all();
    logic fl, fo;
    fl = (m_cur == 1 || m_cur == 4);
    fo = (m_cur == 3 || m_cur == 5);
    chk("pending",    32'(pending),    32'(m_pend));
    chk("in_service", 32'(in_service), 32'(svc()));
    chk("depth",      32'(depth),      32'(m_stk.size()));
    chk("flush_fd",   32'(flush_fd),   32'(fl));
    chk("flush_de",   32'(flush_de),   32'(fl));
    chk("flush_ee",   32'(flush_ee),   32'(fl));
    chk("force",      32'(force_pc),   32'(fo));
    chk("faddr",      faddr,           m_faddr);
    chk("busy",       32'(busy),       32'(m_cur != 0));
    chk("err",        32'(err),        32'(m_err));
  endtask

  // One clock: model consumes the inputs that the DUT will see at the edge.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run_until_force(input int max, output int n);
    n = 0;
    do begin cyc(); n++; end while (!force_pc && n < max);
    if (!force_pc) chk("force_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_eret();
    eret = 1'b1; cyc(); eret = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1; en = 1'b1; gie = 1'b1; eret = 1'b0; mask = '0;
    irq = 4'b0100; wb_pc = 32'h0000_0048;

    // 1: line held high through reset must not fire
    repeat (2) cyc();
    rst = 1'b0;
    repeat (4) cyc();
    chk("t1_pending", 32'(pending), 32'h0);
    chk("t1_force",   32'(force_pc), 32'h0);

    // 2: src 2 edge -> vector 0x220
    irq = 4'b0000; cyc();
    irq = 4'b0100;
    run_until_force(10, n);
    chk("t2_faddr", faddr, 32'h0000_0220);
    chk("t2_insvc", 32'(in_service), 32'h4);
    chk("t2_depth", 32'(depth), 32'd1);
    chk("t2_lat",   32'(n), 32'd4);
    cyc();

    // 3: lower-priority src 1 waits, src 3 nests
    irq = 4'b0110; wb_pc = 32'h0000_0100;
    repeat (4) cyc();
    chk("t3_pend1", 32'(pending), 32'h2);
    irq = 4'b1110; wb_pc = 32'h0000_0060;
    run_until_force(10, n);
    chk("t3_faddr", faddr, 32'h0000_0230);
    chk("t3_depth", 32'(depth), 32'd2);
    cyc();

    // 4: unwind twice, then pending src 1 is taken
    wb_pc = 32'h0000_0300;
    pulse_eret();
    run_until_force(10, n);
    chk("t4_faddr1", faddr, 32'h0000_0060);
    chk("t4_depth1", 32'(depth), 32'd1);
    chk("t4_insvc1", 32'(in_service), 32'h4);
    cyc();
    pulse_eret();
    run_until_force(10, n);
    chk("t4_faddr2", faddr, 32'h0000_0048);
    chk("t4_depth2", 32'(depth), 32'd0);
    run_until_force(10, n);
    chk("t4_src1", faddr, 32'h0000_0210);
    cyc();
    pulse_eret();
    run_until_force(10, n);
    cyc();

    // 5: freeze in FLUSH with en=0
    irq = 4'b0000; cyc();
    irq = 4'b0001;
    n = 0;
    do begin cyc(); n++; end while (!flush_fd && n < 10);
    chk("t5_flush", 32'(flush_fd), 32'd1);
    en = 1'b0;
    repeat (5) cyc();
    chk("t5_hold", 32'(flush_fd), 32'd1);
    en = 1'b1;
    run_until_force(10, n);
    chk("t5_lat", 32'(n), 32'd2);
    chk("t5_faddr", faddr, 32'h0000_0200);
    cyc();
    pulse_eret();
    run_until_force(10, n);
    cyc();

    // 6: eret with empty stack
    pulse_eret();
    chk("t6_err",   32'(err), 32'd1);
    chk("t6_force", 32'(force_pc), 32'd0);
    chk("t6_busy",  32'(busy), 32'd0);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("t6_errclr", 32'(err), 32'd0);

    // randomized traffic
    for (int t = 0; t < 3000; t++) begin
      for (int b = 0; b < NSRC; b++) if ($urandom_range(0, 5) == 0) irq[b] = ~irq[b];
      if ($urandom_range(0, 15) == 0) mask = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      gie   = ($urandom_range(0, 9) != 0);
      en    = ($urandom_range(0, 4) != 0);
      eret  = ($urandom_range(0, 7) == 0);
      wb_pc = $urandom;
      rst   = ($urandom_range(0, 999) == 0);
      cyc();
    end
    rst = 1'b0; eret = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
